// File: rtl/arp_pkg.sv
// Shared types and constants for the ARP resolver: FSM states, cache entry layout,
// and small address-classification helpers.
package arp_pkg;

  localparam int unsigned IP_W  = 32;
  localparam int unsigned MAC_W = 48;

  localparam logic [MAC_W-1:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0]      ETH_TYPE_ARP  = 16'h0806;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    QUERY,
    WAIT_REPLY,
    RESPOND
  } arp_state_t;

  typedef struct packed {
    logic             valid;
    logic [IP_W-1:0]  ip;
    logic [MAC_W-1:0] mac;
  } arp_entry_t;

  // Limited broadcast or the directed broadcast of the local subnet.
  function automatic logic is_broadcast_ip(input logic [IP_W-1:0] ip,
                                           input logic [IP_W-1:0] mask);
    return (ip == '1) || ((ip | mask) == '1);
  endfunction

  // 0.0.0.0 and 255.255.255.255 are never valid ARP sender addresses.
  function automatic logic is_learnable_ip(input logic [IP_W-1:0] ip);
    return (ip != '0) && (ip != '1);
  endfunction

endpackage

// File: rtl/arp_cache.sv
// Fully-associative IP->MAC cache: parallel lookup, learn/overwrite with a
// round-robin victim pointer, and a bulk clear.
module arp_cache
  import arp_pkg::*;
#(
  parameter int unsigned ENTRIES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [IP_W-1:0]  lookup_ip,
  output logic             hit_c,
  output logic [MAC_W-1:0] hit_mac_c,
  input  logic             learn_valid,
  input  logic [IP_W-1:0]  learn_ip,
  input  logic [MAC_W-1:0] learn_mac
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  arp_entry_t       entries [ENTRIES];
  logic [IDX_W-1:0] victim;
  logic             learn_ok;
  logic             learn_match;
  logic [IDX_W-1:0] learn_idx;

  // Parallel compare against the stored entries (pre-write contents).
  always_comb begin : lookup
    hit_c     = 1'b0;
    hit_mac_c = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (!hit_c && entries[i].valid && (entries[i].ip == lookup_ip)) begin
        hit_c     = 1'b1;
        hit_mac_c = entries[i].mac;
      end
    end
  end

  // A clear empties the cache first, so a simultaneous learn lands in slot 0.
  always_comb begin : learn_select
    learn_ok    = learn_valid && is_learnable_ip(learn_ip);
    learn_match = 1'b0;
    learn_idx   = victim;
    if (clear) begin
      learn_idx = '0;
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (!learn_match && entries[i].valid && (entries[i].ip == learn_ip)) begin
          learn_match = 1'b1;
          learn_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin : storage
    if (!reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entries[i] <= '0;
      end
      victim <= '0;
    end else begin
      if (clear) begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
          entries[i].valid <= 1'b0;
        end
      end
      if (learn_ok) begin
        entries[learn_idx] <= '{valid: 1'b1, ip: learn_ip, mac: learn_mac};
      end
      if (clear) begin
        victim <= learn_ok ? IDX_W'(1) : '0;
      end else if (learn_ok && !learn_match) begin
        victim <= victim + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/arp_resolver.sv
// ARP resolution engine: next-hop selection, cache lookup, who-has query with
// timeout/retry, and a held response toward the IP transmit path.
module arp_resolver
  import arp_pkg::*;
#(
  parameter int unsigned CACHE_ENTRIES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 125000,
  parameter int unsigned RETRY_COUNT    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IP_W-1:0]  local_ip,
  input  logic [IP_W-1:0]  subnet_mask,
  input  logic [IP_W-1:0]  gateway_ip,
  input  logic             arp_req_valid,
  input  logic [IP_W-1:0]  arp_req_ip,
  output logic             arp_req_ready,
  output logic             arp_rsp_valid,
  output logic             arp_rsp_err,
  output logic [MAC_W-1:0] arp_rsp_mac,
  input  logic             arp_rsp_ready,
  output logic             query_valid,
  output logic [IP_W-1:0]  query_ip,
  input  logic             query_ready,
  input  logic             reply_valid,
  input  logic [IP_W-1:0]  reply_ip,
  input  logic [MAC_W-1:0] reply_mac,
  input  logic             cache_clear
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RTY_W = (RETRY_COUNT < 1) ? 1 : $clog2(RETRY_COUNT + 1);

  arp_state_t       state, state_d;
  logic [TMR_W-1:0] timer, timer_d;
  logic [RTY_W-1:0] retries, retries_d;
  logic [IP_W-1:0]  target_q, req_target;
  logic             req_bcast;
  logic             target_load_d;
  logic             rsp_load_d;
  logic [MAC_W-1:0] rsp_mac_d;
  logic             rsp_err_d;
  logic             rsp_valid_d;
  logic             reply_match;
  logic             cache_hit;
  logic [MAC_W-1:0] cache_mac;

  arp_cache #(
    .ENTRIES (CACHE_ENTRIES)
  ) u_cache (
    .clk         (clk),
    .reset       (reset),
    .clear       (cache_clear),
    .lookup_ip   (target_q),
    .hit_c       (cache_hit),
    .hit_mac_c   (cache_mac),
    .learn_valid (reply_valid),
    .learn_ip    (reply_ip),
    .learn_mac   (reply_mac)
  );

  // Off-subnet destinations resolve to the gateway.
  always_comb begin : target_select
    req_bcast  = is_broadcast_ip(arp_req_ip, subnet_mask);
    req_target = ((arp_req_ip & subnet_mask) != (local_ip & subnet_mask)) ? gateway_ip
                                                                          : arp_req_ip;
    reply_match = reply_valid && is_learnable_ip(reply_ip) && (reply_ip == target_q);
  end

  always_ff @(posedge clk or negedge reset) begin : state_reg
    if (!reset) begin
      state    <= IDLE;
      timer    <= '0;
      retries  <= '0;
      target_q <= '0;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      retries <= retries_d;
      if (target_load_d) begin
        target_q <= req_target;
      end
    end
  end

  always_comb begin : fsm_next
    state_d       = state;
    timer_d       = timer;
    retries_d     = retries;
    target_load_d = 1'b0;
    rsp_load_d    = 1'b0;
    rsp_mac_d     = '0;
    rsp_err_d     = 1'b0;
    // The response asserts one cycle after RESPOND is entered and drops on handshake.
    rsp_valid_d   = (state == RESPOND) && !(arp_rsp_valid && arp_rsp_ready);
    case (state)
      IDLE: begin
        if (arp_req_valid && arp_req_ready) begin
          target_load_d = 1'b1;
          if (req_bcast) begin
            state_d    = RESPOND;
            rsp_load_d = 1'b1;
            rsp_mac_d  = BROADCAST_MAC;
          end else begin
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (cache_hit) begin
          state_d    = RESPOND;
          rsp_load_d = 1'b1;
          rsp_mac_d  = cache_mac;
        end else begin
          state_d = QUERY;
        end
      end
      QUERY: begin
        if (query_valid && query_ready) begin
          state_d = WAIT_REPLY;
          timer_d = TMR_W'(TIMEOUT_CYCLES - 1);
        end
      end
      WAIT_REPLY: begin
        if (reply_match) begin
          state_d    = RESPOND;
          rsp_load_d = 1'b1;
          rsp_mac_d  = reply_mac;
        end else if (timer == '0) begin
          if (retries < RTY_W'(RETRY_COUNT)) begin
            retries_d = retries + RTY_W'(1);
            state_d   = QUERY;
          end else begin
            state_d    = RESPOND;
            rsp_load_d = 1'b1;
            rsp_err_d  = 1'b1;
          end
        end else begin
          timer_d = timer - TMR_W'(1);
        end
      end
      RESPOND: begin
        if (arp_rsp_valid && arp_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      retries_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin : out_reg
    if (!reset) begin
      arp_req_ready <= 1'b0;
      arp_rsp_valid <= 1'b0;
      arp_rsp_err   <= 1'b0;
      arp_rsp_mac   <= '0;
      query_valid   <= 1'b0;
      query_ip      <= '0;
    end else begin
      arp_req_ready <= (state_d == IDLE);
      arp_rsp_valid <= rsp_valid_d;
      query_valid   <= (state_d == QUERY);
      if (state_d == QUERY) begin
        query_ip <= target_q;
      end
      if (rsp_load_d) begin
        arp_rsp_mac <= rsp_mac_d;
        arp_rsp_err <= rsp_err_d;
      end
    end
  end

endmodule

// File: tb/tb_arp_resolver.sv
// Randomized self-checking bench for arp_resolver against a transaction-level
// model of next-hop selection and a round-robin IP/MAC cache.
module tb_arp_resolver;

  localparam int unsigned N_ENT = 4;
  localparam int unsigned TMO   = 16;
  localparam int unsigned RTY   = 2;
  localparam logic [31:0] LOCAL = 32'hC0A8_010A;
  localparam logic [31:0] MASK  = 32'hFFFF_FF00;
  localparam logic [31:0] GW    = 32'hC0A8_0101;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] local_ip, subnet_mask, gateway_ip;
  logic        arp_req_valid, arp_req_ready;
  logic [31:0] arp_req_ip;
  logic        arp_rsp_valid, arp_rsp_err, arp_rsp_ready;
  logic [47:0] arp_rsp_mac;
  logic        query_valid, query_ready;
  logic [31:0] query_ip;
  logic        reply_valid;
  logic [31:0] reply_ip;
  logic [47:0] reply_mac;
  logic        cache_clear;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_ip  [N_ENT];
  logic [47:0] m_mac [N_ENT];
  bit          m_val [N_ENT];
  int          m_ptr;

  arp_resolver #(
    .CACHE_ENTRIES  (N_ENT),
    .TIMEOUT_CYCLES (TMO),
    .RETRY_COUNT    (RTY)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .local_ip      (local_ip),
    .subnet_mask   (subnet_mask),
    .gateway_ip    (gateway_ip),
    .arp_req_valid (arp_req_valid),
    .arp_req_ip    (arp_req_ip),
    .arp_req_ready (arp_req_ready),
    .arp_rsp_valid (arp_rsp_valid),
    .arp_rsp_err   (arp_rsp_err),
    .arp_rsp_mac   (arp_rsp_mac),
    .arp_rsp_ready (arp_rsp_ready),
    .query_valid   (query_valid),
    .query_ip      (query_ip),
    .query_ready   (query_ready),
    .reply_valid   (reply_valid),
    .reply_ip      (reply_ip),
    .reply_mac     (reply_mac),
    .cache_clear   (cache_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_target(input logic [31:0] ip);
    return ((ip & MASK) != (LOCAL & MASK)) ? GW : ip;
  endfunction

  function automatic bit exp_bcast(input logic [31:0] ip);
    return (ip == 32'hFFFF_FFFF) || ((ip | MASK) == 32'hFFFF_FFFF);
  endfunction

  function automatic void model_clear();
    foreach (m_val[i]) m_val[i] = 1'b0;
    m_ptr = 0;
  endfunction

  // Clear (if any) takes effect before the learn in the same cycle.
  function automatic void model_learn(input logic [31:0] ip, input logic [47:0] mac, input bit clr);
    bit done = 1'b0;
    if (clr) model_clear();
    if (ip == 32'h0 || ip == 32'hFFFF_FFFF) return;
    foreach (m_val[i]) begin
      if (!done && m_val[i] && m_ip[i] == ip) begin
        m_mac[i] = mac;
        done = 1'b1;
      end
    end
    if (!done) begin
      m_val[m_ptr] = 1'b1;
      m_ip[m_ptr]  = ip;
      m_mac[m_ptr] = mac;
      m_ptr = (m_ptr + 1) % N_ENT;
    end
  endfunction

  function automatic void model_lookup(input logic [31:0] ip, output bit hit, output logic [47:0] mac);
    hit = 1'b0;
    mac = '0;
    foreach (m_val[i]) begin
      if (!hit && m_val[i] && m_ip[i] == ip) begin
        hit = 1'b1;
        mac = m_mac[i];
      end
    end
  endfunction

  task automatic learn(input logic [31:0] ip, input logic [47:0] mac, input bit clr);
    reply_valid = 1'b1;
    reply_ip    = ip;
    reply_mac   = mac;
    cache_clear = clr;
    tick();
    reply_valid = 1'b0;
    cache_clear = 1'b0;
    model_learn(ip, mac, clr);
  endtask

  function automatic logic [31:0] pick_ip();
    case ($urandom_range(0, 9))
      0:       return 32'hC0A8_01FF;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0808_0808;
      3:       return 32'h0101_0101;
      default: return {24'hC0A801, 8'($urandom_range(1, 6))};
    endcase
  endfunction

  // One request end to end: responder drives query_ready/reply, then compares to the model.
  task automatic req_check(input string tag, input logic [31:0] ip, input bit give_reply,
                           input int qhold, input int rhold);
    logic [31:0] tgt, qip, sqip;
    logic [47:0] hmac, rmac, smac, emac;
    logic        serr, eerr;
    bit          bc, hit, got, stable, seen_q, replied, qr, hs;
    int          k, nq, rdly, qwait, enq, elat;
    tgt  = exp_target(ip);
    bc   = exp_bcast(ip);
    model_lookup(tgt, hit, hmac);
    rmac = {16'($urandom), $urandom};
    check({tag, "_rdy"}, 64'(arp_req_ready), 64'd1);
    arp_req_valid = 1'b1;
    arp_req_ip    = ip;
    tick();
    arp_req_valid = 1'b0;
    arp_req_ip    = $urandom;
    k = 0; nq = 0; rdly = -1; qwait = 0;
    got = 1'b0; stable = 1'b1; seen_q = 1'b0; replied = 1'b0;
    qip = '0; sqip = '0;
    while (!got && k < 600) begin
      reply_valid = 1'b0;
      if (arp_rsp_valid) begin
        got = 1'b1;
      end else begin
        if (rdly == 0 && !replied) begin
          reply_valid = 1'b1;
          reply_ip    = tgt;
          reply_mac   = rmac;
          replied     = 1'b1;
          model_learn(tgt, rmac, 1'b0);
        end else if (rdly > 0) begin
          rdly--;
        end
        qr = 1'b0;
        if (query_valid) begin
          if (!seen_q) begin
            seen_q = 1'b1;
            sqip   = query_ip;
          end else if (query_ip !== sqip) begin
            stable = 1'b0;
          end
          qr = (qwait >= qhold) && ($urandom_range(0, 3) != 0);
          qwait++;
        end
        hs = query_valid && qr;
        query_ready = qr;
        tick();
        k++;
        if (hs) begin
          nq++;
          qip    = sqip;
          seen_q = 1'b0;
          if (give_reply && nq == 1) rdly = $urandom_range(0, 4);
        end
      end
    end
    query_ready = 1'b0;
    reply_valid = 1'b0;
    check({tag, "_got"}, 64'(got), 64'd1);
    smac = arp_rsp_mac;
    serr = arp_rsp_err;
    for (int i = 0; i < rhold; i++) begin
      tick();
      if (!arp_rsp_valid || arp_rsp_mac !== smac || arp_rsp_err !== serr) stable = 1'b0;
    end
    arp_rsp_ready = 1'b1;
    tick();
    arp_rsp_ready = 1'b0;
    check({tag, "_after"}, 64'({arp_rsp_valid, arp_req_ready}), 64'b01);
    check({tag, "_stable"}, 64'(stable), 64'd1);
    eerr = 1'b0;
    elat = -1;
    if (bc) begin
      enq = 0; emac = 48'hFFFF_FFFF_FFFF; elat = 1;
    end else if (hit) begin
      enq = 0; emac = hmac; elat = 2;
    end else if (give_reply) begin
      enq = 1; emac = rmac;
    end else begin
      enq = RTY + 1; emac = '0; eerr = 1'b1;
    end
    check({tag, "_mac"}, 64'(smac), 64'(emac));
    check({tag, "_err"}, 64'(serr), 64'(eerr));
    check({tag, "_nq"}, 64'(nq), 64'(enq));
    if (elat >= 0) check({tag, "_lat"}, 64'(k), 64'(elat));
    if (enq > 0) check({tag, "_qip"}, 64'(qip), 64'(tgt));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 64'({arp_req_ready, arp_rsp_valid, arp_rsp_err, query_valid}), 64'd0);
    check({tag, "_mac"}, 64'(arp_rsp_mac), 64'd0);
    check({tag, "_qip"}, 64'(query_ip), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b0;
    local_ip = LOCAL; subnet_mask = MASK; gateway_ip = GW;
    arp_req_valid = 1'b0; arp_req_ip = '0; arp_rsp_ready = 1'b0; query_ready = 1'b0;
    reply_valid = 1'b0; reply_ip = '0; reply_mac = '0; cache_clear = 1'b0;
    model_clear();
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    check("rdy_rel", 64'(arp_req_ready), 64'd0);
    tick();
    check("rdy_first", 64'(arp_req_ready), 64'd1);

    learn(32'hC0A8_0114, 48'h0200_0000_0014, 1'b0);
    req_check("hit20", 32'hC0A8_0114, 1'b0, 0, 0);
    req_check("gw_miss", 32'h0808_0808, 1'b1, 0, 0);
    req_check("gw_hit", 32'h0808_0808, 1'b0, 0, 0);
    req_check("bcast", 32'hC0A8_01FF, 1'b0, 0, 0);
    req_check("timeout", 32'hC0A8_0163, 1'b0, 5, 10);

    learn(32'h0, 48'h0, 1'b1);
    for (int i = 0; i < 5; i++) learn(32'hC0A8_011F + 32'(i), 48'h0200_0000_0100 + 48'(i), 1'b0);
    req_check("evict", 32'hC0A8_011F, 1'b1, 0, 0);
    req_check("hit5", 32'hC0A8_0123, 1'b0, 0, 0);
    learn(32'hC0A8_0121, 48'h0200_0000_0AAA, 1'b0);
    req_check("ovr", 32'hC0A8_0121, 1'b0, 0, 0);
    req_check("keep", 32'hC0A8_0122, 1'b1, 0, 0);
    learn(32'hFFFF_FFFF, 48'h0200_0000_0BBB, 1'b0);
    learn(32'hC0A8_0124, 48'h0200_0000_0CCC, 1'b1);
    req_check("clr_keep", 32'hC0A8_0124, 1'b1, 0, 0);
    req_check("clr_gone", 32'hC0A8_0122, 1'b1, 0, 0);

    arp_req_valid = 1'b1;
    arp_req_ip    = 32'hC0A8_014D;
    tick();
    arp_req_valid = 1'b0;
    cnt = 0;
    while (!query_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("rst_q_seen", 64'(query_valid), 64'd1);
    query_ready = 1'b1;
    tick();
    query_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) tick();
    reset = 1'b1;
    model_clear();
    arp_rsp_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (arp_rsp_valid || query_valid) cnt++;
    end
    arp_rsp_ready = 1'b0;
    check("rst_no_rsp", 64'(cnt), 64'd0);
    req_check("rst_empty", 32'hC0A8_0124, 1'b1, 0, 0);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [31:0] lip;
        case ($urandom_range(0, 7))
          0:       lip = 32'h0;
          1:       lip = 32'hFFFF_FFFF;
          default: lip = pick_ip();
        endcase
        learn(lip, {16'h0200, $urandom}, $urandom_range(0, 9) == 0);
      end
      req_check("rnd", pick_ip(), $urandom_range(0, 3) != 0, 0, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
